router_weight_mc: RTL
=====================

ROUTER_WEIGHT_MC -- requirements
Module: router_weight_mc

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_BITWIDTH, 16, weight word width; ADDR_BITWIDTH_GLB, 10, GLB address width; NUM_CH, 3, destination spad channels; KERNEL_SIZE, 3, words per filter = KERNEL_SIZE**2; W_READ_ADDR, 0, GLB base address; CH_STRIDE, 9, GLB address offset between per-channel filters.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; reset_n in 1 async active-low reset.
REQ-003 r_data_glb_wght in DATA_BITWIDTH GLB read data, valid exactly 1 cycle after read_req_glb_wght.
REQ-004 r_addr_glb_wght out ADDR_BITWIDTH_GLB GLB read address; read_req_glb_wght out 1 GLB read strobe.
REQ-005 w_data_spad out DATA_BITWIDTH word to spads; load_en_spad out NUM_CH per-channel write valid.
REQ-006 spad_ready in NUM_CH per-channel accept; a word transfers on channel c when load_en_spad[c] and spad_ready[c] are both high.
REQ-007 load_spad_ctrl in 1 start pulse; ch_mask in NUM_CH target channels; multicast in 1 mode select; both sampled only at start.
REQ-008 busy out 1 operation in progress; done out 1 single-cycle completion pulse.
REQ-009 One clock (clk); reset is asynchronous and active-low (reset_n).

Function
REQ-010 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-011 IDLE: load_spad_ctrl=1 latches ch_mask/multicast, enters READ; ch_mask==0 instead enters DONE directly, with no GLB read.
REQ-012 load_spad_ctrl SHALL be ignored while busy=1.
REQ-013 Multicast: KERNEL_SIZE**2 words read once from W_READ_ADDR upward; each word presented to all masked channels simultaneously; it retires only when every masked channel has accepted it (per-channel accepted flags; a channel already accepted is not re-enabled).
REQ-014 Unicast: masked channels served in ascending index; channel c reads KERNEL_SIZE**2 words from W_READ_ADDR + c*CH_STRIDE upward; only load_en_spad[c] asserted.
REQ-015 Reads SHALL be issued only when the output skid buffer has a free slot accounting for the in-flight read; no word lost or duplicated under any spad_ready pattern.
REQ-016 With all targets ready continuously: one word per cycle; first load_en_spad 2 cycles after start; done asserted 1 cycle after the last transfer.
REQ-017 READ -> DRAIN when the last read of the last channel is issued; DRAIN -> DONE when the buffer is empty and the last word accepted; DONE -> IDLE unconditionally, done=1 for that cycle.
REQ-018 Address arithmetic SHALL be modulo 2**ADDR_BITWIDTH_GLB (wrap, no error).
REQ-019 Word counter width SHALL be $clog2(KERNEL_SIZE**2+1); channel index $clog2(NUM_CH) (min 1).
REQ-020 w_data_spad SHALL hold stable while any load_en_spad bit is high and not all accepted.
REQ-021 busy=1 in READ, DRAIN, DONE; 0 in IDLE.

Reset
REQ-022 reset_n low SHALL asynchronously force: state IDLE, read_req_glb_wght 0, r_addr_glb_wght W_READ_ADDR, load_en_spad 0, w_data_spad 0, busy 0, done 0, counters and skid buffer empty.
REQ-023 Reset mid-operation SHALL abandon the transfer; no done pulse; next start begins from word 0.

Structure
REQ-024 FSM state enum and a KERNEL_WORDS helper SHALL live in shared package router_pkg.
REQ-025 Two-entry skid buffer SHALL be sub-module router_skid_buf (parameter DATA_BITWIDTH; push/pop/full/empty).

Verification
REQ-026 Multicast, mask 3'b111, all ready -> addresses 0..8 once, all three load_en bits high for 9 words, done at cycle 11 after start.
REQ-027 Unicast, mask 3'b101 -> channel 0 gets GLB words 0..8, channel 2 gets 18..26, channel 1 never enabled, done once.
REQ-028 Multicast, mask 3'b011, spad_ready[1] low for 4 cycles on word 3 -> channel 0 accepts word 3 once, data held, no read beyond buffer capacity, 9 words per channel in order.
REQ-029 Start with mask 0 -> no read_req, done pulse 1 cycle later; start pulse while busy -> ignored, single done.
REQ-030 reset_n low at word 5 -> outputs to reset values immediately; restart delivers words 0..8 with one done.
REQ-031 W_READ_ADDR=1020, ADDR_BITWIDTH_GLB=10 -> addresses 1020..1023,0..4.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the weight router: controller state encoding and
// the filter-size helper used to size word counters.
package router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } router_state_e;

    // Number of weight words in one square filter.
    function automatic int kernel_words(input int kernel_size);
        return kernel_size * kernel_size;
    endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry FIFO that decouples GLB reads from spad acceptance.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   push, din    : write one entry (ignored when full)
//   pop          : retire the head entry (ignored when empty)
//   dout         : head entry (stale but stable when empty)
//   full, empty  : occupancy flags
module router_skid_buf #(
    parameter int DATA_BITWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_BITWIDTH-1:0] din,
    output logic [DATA_BITWIDTH-1:0] dout,
    output logic                     full,
    output logic                     empty
);

    logic [DATA_BITWIDTH-1:0] mem_q [2];
    logic [DATA_BITWIDTH-1:0] mem_d [2];
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     do_push, do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/router_weight_mc.sv
// Weight router: fetches KERNEL_SIZE**2 filter words from the GLB and loads
// them into spad channels, either multicast (one read stream shared by all
// masked channels) or unicast (one filter per masked channel, ascending).
//
// state | meaning
// IDLE  | waiting for load_spad_ctrl
// READ  | issuing GLB reads as buffer credit allows
// DRAIN | all reads issued, waiting for the last word to retire
// DONE  | one-cycle completion, done=1
//
// Ports:
//   clk, reset_n                : clock, async active-low reset
//   r_data_glb_wght             : GLB data, valid one cycle after read_req
//   r_addr_glb_wght, read_req_glb_wght : GLB read address / strobe
//   w_data_spad, load_en_spad   : word and per-channel valid to spads
//   spad_ready                  : per-channel accept
//   load_spad_ctrl, ch_mask, multicast : start pulse and its operands
//   busy, done                  : in progress / completion pulse
module router_weight_mc
    import router_pkg::*;
#(
    parameter int DATA_BITWIDTH     = 16,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int NUM_CH            = 3,
    parameter int KERNEL_SIZE       = 3,
    parameter int W_READ_ADDR       = 0,
    parameter int CH_STRIDE         = 9
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DATA_BITWIDTH-1:0]     r_data_glb_wght,
    output logic [ADDR_BITWIDTH_GLB-1:0] r_addr_glb_wght,
    output logic                         read_req_glb_wght,
    output logic [DATA_BITWIDTH-1:0]     w_data_spad,
    output logic [NUM_CH-1:0]            load_en_spad,
    input  logic [NUM_CH-1:0]            spad_ready,
    input  logic                         load_spad_ctrl,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic                         multicast,
    output logic                         busy,
    output logic                         done
);

    localparam int KW     = kernel_words(KERNEL_SIZE);
    localparam int WCNT_W = $clog2(KW + 1);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW     = ADDR_BITWIDTH_GLB;
    // Buffer entry: {last word of operation, channel, data}
    localparam int TAG_W  = DATA_BITWIDTH + CH_W + 1;

    router_state_e       state_q, state_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                mc_q, mc_d;
    logic [WCNT_W-1:0]   rd_word_q, rd_word_d;
    logic [CH_W-1:0]     rd_ch_q, rd_ch_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;
    logic [CH_W-1:0]     inflight_ch_q, inflight_ch_d;
    logic [NUM_CH-1:0]   acc_q, acc_d;

    logic                buf_push, buf_pop, buf_full, buf_empty;
    logic [TAG_W-1:0]    buf_dout, head_tag;
    logic [1:0]          buf_cnt;
    logic [2:0]          occ;
    logic                head_valid, head_last, pop, can_issue;
    logic [CH_W-1:0]     head_ch;
    logic [NUM_CH-1:0]   target;
    logic                word_last, last_read;
    logic [CH_W:0]       nxt_sel, first_sel;

    // Lowest masked channel index strictly above 'after'; MSB flags found.
    function automatic logic [CH_W:0] find_ch(input logic [NUM_CH-1:0] m,
                                              input int after);
        logic [CH_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i > after && m[i]) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    router_skid_buf #(.DATA_BITWIDTH(TAG_W)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (buf_push),
        .pop     (buf_pop),
        .din     ({inflight_last_q, inflight_ch_q, r_data_glb_wght}),
        .dout    (buf_dout),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    // The in-flight word falls through to the spads when the buffer is
    // empty, so a continuously ready target sees one word per cycle.
    assign head_valid = !buf_empty || inflight_q;
    assign head_tag   = buf_empty ? {inflight_last_q, inflight_ch_q, r_data_glb_wght}
                                  : buf_dout;
    assign head_last  = head_tag[TAG_W-1];
    assign head_ch    = head_tag[TAG_W-2 -: CH_W];
    assign target     = mc_q ? mask_q : (NUM_CH'(1) << head_ch);

    assign load_en_spad = head_valid ? (target & ~acc_q) : '0;
    assign w_data_spad  = head_valid ? head_tag[DATA_BITWIDTH-1:0] : '0;

    // Retire once every targeted channel has accepted, now or earlier.
    assign pop      = head_valid && ((target & ~acc_q & ~spad_ready) == '0);
    assign buf_push = inflight_q && !(buf_empty && pop);
    assign buf_pop  = pop && !buf_empty;

    // Credit: stored words plus the in-flight read, less this cycle's pop,
    // must leave a slot for the word a new read will return.
    assign buf_cnt   = buf_full ? 2'd2 : (buf_empty ? 2'd0 : 2'd1);
    assign occ       = {1'b0, buf_cnt} + {2'b0, inflight_q} - {2'b0, pop};
    assign can_issue = (state_q == ST_READ) && (occ < 3'd2);

    assign word_last = (rd_word_q == WCNT_W'(KW - 1));
    assign nxt_sel   = find_ch(mask_q, int'(rd_ch_q));
    assign first_sel = find_ch(ch_mask, -1);
    assign last_read = word_last && (mc_q || !nxt_sel[CH_W]);

    assign read_req_glb_wght = can_issue;
    assign r_addr_glb_wght   = AW'(W_READ_ADDR)
                             + (mc_q ? AW'(0) : AW'(rd_ch_q) * AW'(CH_STRIDE))
                             + AW'(rd_word_q);

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    always_comb begin
        state_d         = state_q;
        mask_d          = mask_q;
        mc_d            = mc_q;
        rd_word_d       = rd_word_q;
        rd_ch_d         = rd_ch_q;
        inflight_d      = 1'b0;
        inflight_last_d = inflight_last_q;
        inflight_ch_d   = inflight_ch_q;
        acc_d           = pop ? '0 : (acc_q | (load_en_spad & spad_ready));

        if (can_issue) begin
            inflight_d      = 1'b1;
            inflight_last_d = last_read;
            inflight_ch_d   = rd_ch_q;
            if (word_last) begin
                rd_word_d = '0;
                if (!mc_q) rd_ch_d = nxt_sel[CH_W-1:0];
            end else begin
                rd_word_d = rd_word_q + WCNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (load_spad_ctrl) begin
                    mask_d    = ch_mask;
                    mc_d      = multicast;
                    rd_word_d = '0;
                    rd_ch_d   = first_sel[CH_W-1:0];
                    state_d   = first_sel[CH_W] ? ST_READ : ST_DONE;
                end
            end
            ST_READ: begin
                if (can_issue && last_read) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && head_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            mask_q          <= '0;
            mc_q            <= 1'b0;
            rd_word_q       <= '0;
            rd_ch_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            inflight_ch_q   <= '0;
            acc_q           <= '0;
        end else begin
            state_q         <= state_d;
            mask_q          <= mask_d;
            mc_q            <= mc_d;
            rd_word_q       <= rd_word_d;
            rd_ch_q         <= rd_ch_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            inflight_ch_q   <= inflight_ch_d;
            acc_q           <= acc_d;
        end
    end

endmodule
